// File: rtl/spart_pkg.sv
// Shared SPART types and constants used by the receive and transmit stages.
package spart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [1:0] SPART_ADDR_DATA   = 2'b00;
  localparam logic [1:0] SPART_ADDR_STATUS = 2'b01;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Baud counter values: last tick of a bit period, and mid-bit (used in START)
  localparam logic [3:0] BAUD_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BAUD_MID  = 4'(OVERSAMPLE / 2 - 1);

endpackage

// File: rtl/sync_ff.sv
// Flop chain resetting to 1 for bringing an idle-high async line into clk; STAGES clocks latency.
// No flow control: samples every clock.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: 16x-oversampled 8N1 deserializer with RDA/FERR/OVR flags on the databus.
// RDA rises the cycle after the mid-stop-bit sample; no backpressure, an unread byte is overwritten (OVR).
module spart_rx
  import spart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] addr,
  input  logic       iorw,
  input  logic       iocs,
  input  logic       RX,
  output logic [7:0] rx_out,
  output logic       RDA
);

  rx_state_t  state;
  logic       rx_s;
  logic [3:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [3:0] bit_nxt;
  logic [7:0] shift_reg;
  logic [7:0] data_reg;
  logic       ovr;
  logic       ferr;

  logic rd_data;
  logic rd_status;
  logic stop_done;
  logic load_byte;
  logic ferr_set;
  logic ovr_set;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  assign rd_data   = iocs & iorw & (addr == SPART_ADDR_DATA);
  assign rd_status = iocs & iorw & (addr == SPART_ADDR_STATUS);

  assign stop_done = (state == RX_STOP) & enable & (baud_cnt == BAUD_LAST);
  assign load_byte = stop_done & rx_s;
  assign ferr_set  = stop_done & ~rx_s;
  // A byte landing while the host is reading the previous one is not an overrun
  assign ovr_set   = load_byte & RDA & ~rd_data;
  assign bit_nxt   = bit_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      RDA       <= 1'b0;
      ovr       <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      if (load_byte)    RDA <= 1'b1;
      else if (rd_data) RDA <= 1'b0;

      if (ovr_set)        ovr <= 1'b1;
      else if (rd_status) ovr <= 1'b0;

      if (ferr_set)       ferr <= 1'b1;
      else if (rd_status) ferr <= 1'b0;

      if (load_byte) data_reg <= shift_reg;

      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (enable) begin
            if (baud_cnt == BAUD_MID) begin
              baud_cnt <= '0;
              state    <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              baud_cnt <= baud_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (enable) begin
            baud_cnt <= baud_cnt + 4'd1;
            if (baud_cnt == BAUD_LAST) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_nxt;
              if (bit_nxt == 4'(DATA_BITS)) state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (enable) begin
            baud_cnt <= baud_cnt + 4'd1;
            if (baud_cnt == BAUD_LAST) state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_out = 8'h00;
    case (addr)
      SPART_ADDR_DATA:   rx_out = data_reg;
      SPART_ADDR_STATUS: rx_out = {5'b0, ovr, ferr, RDA};
      default:           rx_out = 8'h00;
    endcase
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive stage of the SPART, the counterpart to the transmit stage on the same bus. It oversamples the incoming RX line using the shared 16x-baud `enable` strobe and reassembles 8N1 frames, LSB first. Completed bytes are presented on the internal databus when read at address 0. It flags data-available, framing error and overrun, for use by the bootloader and its testbench loopback.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the RX metastability synchronizer. Legal values are 2 or 3.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst_n`  input  1  reset; synchronous, active-low.
- `enable`  input  1  one-cycle strobe at 16x the baud rate.
- `addr`  input  2  register select. 2'b00 selects data; 2'b01 selects status.
- `iorw`  input  1  read when high.
- `iocs`  input  1  chip select.
- `RX`  input  1  serial line; idles high.
- `rx_out`  output  8  read data. Data register when `addr`=00; {5'b0, OVR, FERR, RDA} when `addr`=01; 8'h00 otherwise.
- `RDA`  output  1  receive data available.

## Operation
**Synchronizer**
- RX passes through `SYNC_STAGES` flops, giving `rx_s`. All stages reset to 1.

**State machine** (IDLE, START, DATA, STOP)
- Baud counter is 4 bits. It increments only on `enable`.
- **IDLE**
  - `rx_s`==0 → START. Baud counter and bit counter are cleared.
- **START**
  - On the 8th `enable` (counter==7 when `enable` arrives), sample `rx_s`.
  - Sample is 0 → DATA, counter cleared.
  - Sample is 1 → IDLE. This is a false start and no flags change.
- **DATA**
  - On each 16th `enable` (counter==15), shift `rx_s` into bit 7 of the shift register, shifting right. Increment the bit counter.
  - After the 8th bit → STOP.
- **STOP**
  - On the 16th `enable`, sample `rx_s`, then → IDLE.
  - Sample is 1: load the data register from the shift register and set `RDA`. If `RDA` was already set and is not being cleared this cycle, also set OVR.
  - Sample is 0: set FERR. The data register and `RDA` are unchanged.

**Bus**
- A read is `iocs & iorw`.
- Data read (`addr`=00) clears `RDA` on the next edge.
- Status read (`addr`=01) clears OVR and FERR on the next edge.
- Writes (`iorw`=0) are ignored entirely.
- `rx_out` is combinational from the registers and the address.

## Timing
**Reset**
- On `rst_n` low at a clock edge:
  - state IDLE; counters 0; shift register and data register 8'h00.
  - `RDA`=0, OVR=0, FERR=0; `rx_out` reads 8'h00.
- Reset mid-frame abandons the frame. The next falling edge after release starts a fresh frame.

**Latency**
- RX falling edge to START is `SYNC_STAGES`+1 clocks.
- Stop-bit sample to `RDA`=1 is visible the cycle after the sampling `enable`.

**Back-to-back frames**
- Return to IDLE happens at mid-stop-bit. A start bit immediately after the stop bit is detected with no lost frame.

**Simultaneous events**
- Data read and completion of a new byte in the same cycle:
  - new byte loaded, `RDA` stays 1, OVR not set.
  - `rx_out` shows the old byte during that cycle.
- Status read and a new OVR/FERR event in the same cycle: the set wins and the flag stays 1.

**Counters and tolerance**
- `enable` absent: the state machine holds and counters hold.
- Counters wrap 15→0 naturally.
- Bit counter is 4 bits and compares with 8.
- Sampling at mid-bit tolerates at least ±3 % baud mismatch.

## Structure
- Shared `spart_pkg` holds:
  - `rx_state_t` enum.
  - address constants `SPART_ADDR_DATA`=2'b00, `SPART_ADDR_STATUS`=2'b01, shared with the transmit stage.
  - constants `OVERSAMPLE`=16 and `DATA_BITS`=8.
- One sub-module: `sync_ff` (parameterised flop chain, reset to 1), used for the RX synchronizer.
- The FSM, counters, shift register and bus decode live in `spart_rx`.

## Test plan
1. **Single byte:** drive 0x5A as 8N1 at 16 `enable`/bit, then read `addr`=00.
   → `RDA`=1, `rx_out`=0x5A; `RDA`=0 one cycle after the read.
2. **Loopback burst:** connect the transmit stage TX to RX and send 0x00, 0xFF, 0xA5 back-to-back, reading each byte when `RDA` rises.
   → all three bytes match; OVR=0; FERR=0.
3. **False start:** apply a 4-`enable`-long low glitch on RX.
   → returns to IDLE; `RDA`=0; FERR=0.
4. **Framing error:** send 0x33 with the stop bit driven 0.
   → status reads 8'h02; data register still holds its prior value; the status read clears FERR.
5. **Overrun:** send 0x11 then 0x22 without reading.
   → status reads 8'h05; data reads 0x22.
6. **Mid-frame reset:** assert `rst_n`=0 for 1 cycle during bit 4 of 0xC3, then send 0x7E.
   → all outputs are 0 after the reset; the next frame yields 0x7E.
